// File: rtl/wash_phase_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wash_pkg
//  Description : Shared types, phase codes and duration table for the
//                washing-machine phase timer.
//  Revision    : 1.0  initial release
// ============================================================================
package wash_pkg;

    localparam logic [1:0] PH_SOAK  = 2'b00;
    localparam logic [1:0] PH_WASH  = 2'b01;
    localparam logic [1:0] PH_RINSE = 2'b10;
    localparam logic [1:0] PH_SPIN  = 2'b11;

    // Table entries never exceed 16, so 5 bits hold every duration.
    localparam int DUR_W = 5;

    typedef enum logic [1:0] {
        MODE_QUICK  = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_HEAVY  = 2'd2
    } mode_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // {mode1, mode2, mode3}: heavy wins over normal over quick; 000 is quick.
    function automatic mode_idx_t decode_mode(input logic [2:0] mode);
        mode_idx_t m;
        if (mode[2])      m = MODE_HEAVY;
        else if (mode[1]) m = MODE_NORMAL;
        else              m = MODE_QUICK;
        return m;
    endfunction

    // Phase duration in time units.
    function automatic logic [DUR_W-1:0] phase_duration(input mode_idx_t mode_idx,
                                                        input logic [1:0] phase);
        logic [DUR_W-1:0] d;
        d = 5'd2;
        case (mode_idx)
            MODE_HEAVY: begin
                case (phase)
                    PH_SOAK: d = 5'd8;
                    PH_WASH: d = 5'd16;
                    default: d = 5'd6;
                endcase
            end
            MODE_NORMAL: begin
                if (phase == PH_WASH) d = 5'd8;
                else                  d = 5'd4;
            end
            default: begin
                if (phase == PH_WASH) d = 5'd4;
                else                  d = 5'd2;
            end
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wash_phase_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : wash_phase_timer_if
//  Description : Controller <-> phase-timer signal bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface wash_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             timer_enable;
    logic [1:0]       phase_sel;
    logic [2:0]       mode;
    logic             lid;
    logic             cancel;
    logic             timer_done;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             paused;

    // Controller side
    modport master (
        output timer_enable, phase_sel, mode, lid, cancel,
        input  timer_done, remaining, busy, paused
    );

    // Timer side
    modport slave (
        input  timer_enable, phase_sel, mode, lid, cancel,
        output timer_done, remaining, busy, paused
    );
endinterface
`default_nettype wire

// File: rtl/wash_phase_timer_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides clk down to one time-unit tick every TICK_DIV
//                counted cycles; holds while run is low, clears on clr.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic run,
    output logic      tick
);
    localparam int              CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..TICK_DIV-1 while running, wrapping after the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (run)
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CW'(1);
    end

    assign tick = (r_cnt == c_last);
endmodule
`default_nettype wire

// File: rtl/wash_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wash_phase_timer
//  Description : Per-phase duration timer. Loads the mode/phase duration,
//                counts it down on a prescaled time base, pauses on lid open
//                and pulses timer_done for one cycle on expiry.
//  Revision    : 1.0  initial release
// ============================================================================
module wash_phase_timer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    wash_phase_timer_if.slave bus
);
    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_phase_q;
    logic [CNT_W-1:0]   r_remaining;
    logic [DUR_W-1:0]   w_dur;
    logic               w_tick;
    logic               w_pre_clr;
    logic               w_pre_run;
    logic               w_phase_chg;
    logic               w_load;
    logic               w_dec;
    logic               w_clear;

    assign w_dur       = phase_duration(decode_mode(bus.mode), bus.phase_sel);
    assign w_phase_chg = (bus.phase_sel != r_phase_q);

    // Prescaler sits at zero outside the counting states. In a RUN cycle that
    // sees the lid open it still advances (that cycle counts as run time),
    // but it holds on its terminal value so the suppressed tick fires on resume.
    assign w_pre_clr = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign w_pre_run = (r_state == ST_RUN) && !(bus.lid && w_tick);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_pre_clr),
        .run   (w_pre_run),
        .tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and datapath controls, abort conditions first.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_dec   = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (bus.timer_enable && !bus.cancel) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.cancel || !bus.timer_enable) begin
                    w_clear = 1'b1;
                    w_next  = ST_IDLE;
                end else if (w_phase_chg) begin
                    w_next = ST_LOAD;
                end else if (bus.lid) begin
                    w_next = ST_PAUSE;
                end else if (w_tick) begin
                    w_dec = 1'b1;
                    if (r_remaining <= CNT_W'(1)) w_next = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (bus.cancel || !bus.timer_enable) begin
                    w_clear = 1'b1;
                    w_next  = ST_IDLE;
                end else if (w_phase_chg) begin
                    w_next = ST_LOAD;
                end else if (!bus.lid) begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!bus.cancel && bus.timer_enable && w_phase_chg) w_next = ST_LOAD;
                else                                                  w_next = ST_IDLE;
            end
            default: begin
                w_clear = 1'b1;
                w_next  = ST_IDLE;
            end
        endcase
    end

    // Remaining-time counter and latched phase; saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_phase_q   <= PH_SOAK;
        end else begin
            if (w_load) begin
                r_remaining <= CNT_W'(w_dur);
                r_phase_q   <= bus.phase_sel;
            end else if (w_clear) begin
                r_remaining <= '0;
            end else if (w_dec && (r_remaining != '0)) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    assign bus.timer_done = (r_state == ST_DONE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.paused     = (r_state == ST_PAUSE);
    assign bus.remaining  = r_remaining;
endmodule
`default_nettype wire

// File: tb/tb_wash_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wash_phase_timer
//  Description : Self-checking bench for wash_phase_timer (TICK_DIV = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wash_phase_timer;
    localparam int TD = 4;
    localparam int CW = 8;

    typedef struct {
        logic [2:0] mode;
        logic [1:0] ph;
        int         dur;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wash_phase_timer_if #(.CNT_W(CW)) bus ();

    wash_phase_timer #(
        .TICK_DIV (TD),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until timer_done is seen; n = step count, or -1 on timeout.
    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus.timer_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   n;
        int   first_done;
        int   done_seen;
        logic [1:0] ph;

        vecs[0]  = '{3'b001, 2'd0, 2};
        vecs[1]  = '{3'b001, 2'd1, 4};
        vecs[2]  = '{3'b010, 2'd1, 8};
        vecs[3]  = '{3'b010, 2'd3, 4};
        vecs[4]  = '{3'b100, 2'd1, 16};
        vecs[5]  = '{3'b110, 2'd2, 6};
        vecs[6]  = '{3'b011, 2'd0, 4};
        vecs[7]  = '{3'b000, 2'd3, 2};
        vecs[8]  = '{3'b000, 2'd1, 4};
        vecs[9]  = '{3'b101, 2'd0, 8};
        vecs[10] = '{3'b111, 2'd3, 6};

        bus.timer_enable = 1'b0;
        bus.phase_sel    = 2'd0;
        bus.mode         = 3'b000;
        bus.lid          = 1'b0;
        bus.cancel       = 1'b0;

        // Reset state
        step();
        step();
        check("reset_done",      32'(bus.timer_done), 0);
        check("reset_remaining", 32'(bus.remaining),  0);
        check("reset_busy",      32'(bus.busy),       0);
        check("reset_paused",    32'(bus.paused),     0);
        rst_n = 1'b1;
        step();

        // Quick soak, enable held: remaining 0 (LOAD), 2, 1, then 0 with done at step 10
        bus.mode = 3'b001; bus.phase_sel = 2'd0; bus.timer_enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("t1_remaining", 32'(bus.remaining),
                  (i == 1) ? 0 : (i <= 5) ? 2 : (i <= 9) ? 1 : 0);
            check("t1_done", 32'(bus.timer_done), (i == 10) ? 1 : 0);
        end
        step();
        check("t1_idle_after_done", 32'(bus.busy), 0);
        check("t1_pulse_width",     32'(bus.timer_done), 0);
        step();
        check("t1_rearm_load", 32'(bus.busy), 1);
        bus.timer_enable = 1'b0;
        step();
        step();
        check("t1_disable_idle", 32'(bus.busy), 0);

        // Lid open for 5 cycles mid-RUN: done moves from step 10 to step 15
        bus.timer_enable = 1'b1;
        first_done = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 3) bus.lid = 1'b1;
            if (i == 8) bus.lid = 1'b0;
            if (i == 4) check("t2_paused_on", 32'(bus.paused), 1);
            if (i == 8) begin
                check("t2_paused_hold", 32'(bus.paused), 1);
                check("t2_remaining_frozen", 32'(bus.remaining), 2);
            end
            if (i == 9)  check("t2_paused_off", 32'(bus.paused), 0);
            if (i == 11) check("t2_remaining_after", 32'(bus.remaining), 1);
            if (bus.timer_done === 1'b1 && first_done < 0) begin
                first_done = i;
                bus.timer_enable = 1'b0;
            end
        end
        check("t2_done_step", 32'(first_done), 15);

        // Heavy mode, phases walked back to back
        bus.mode = 3'b100; bus.phase_sel = 2'd0; bus.timer_enable = 1'b1;
        wait_done(200, n);
        check("t3_soak_spacing", 32'(n), 34);
        ph = 2'd0;
        for (int p = 1; p <= 3; p++) begin
            ph = ph + 2'd1;
            bus.phase_sel = ph;
            wait_done(200, n);
            check("t3_phase_spacing", 32'(n), (p == 1) ? 66 : 26);
        end
        bus.timer_enable = 1'b0;
        step();
        step();

        // Cancel with remaining = 3 (normal soak), enable still high
        bus.mode = 3'b010; bus.phase_sel = 2'd0; bus.timer_enable = 1'b1;
        for (int i = 1; i <= 6; i++) step();
        check("t4_remaining_pre", 32'(bus.remaining), 3);
        bus.cancel = 1'b1;
        step();
        check("t4_busy",      32'(bus.busy),       0);
        check("t4_remaining", 32'(bus.remaining),  0);
        check("t4_done",      32'(bus.timer_done), 0);
        bus.timer_enable = 1'b0;
        bus.cancel       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.timer_done === 1'b1) done_seen++;
        end
        check("t4_no_done", 32'(done_seen), 0);

        // Duration table vectors
        foreach (vecs[v]) begin
            bus.mode = vecs[v].mode; bus.phase_sel = vecs[v].ph; bus.timer_enable = 1'b1;
            step();
            step();
            check("vec_loaded", 32'(bus.remaining), 32'(vecs[v].dur));
            wait_done(200, n);
            check("vec_latency", 32'(n + 2), 32'(2 + vecs[v].dur * TD));
            bus.timer_enable = 1'b0;
            step();
            step();
        end

        // Asynchronous reset mid-RUN, then full reload
        bus.mode = 3'b001; bus.phase_sel = 2'd0; bus.timer_enable = 1'b1;
        for (int i = 1; i <= 6; i++) step();
        check("t6_pre_remaining", 32'(bus.remaining), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_done",      32'(bus.timer_done), 0);
        check("t6_rst_remaining", 32'(bus.remaining),  0);
        check("t6_rst_busy",      32'(bus.busy),       0);
        check("t6_rst_paused",    32'(bus.paused),     0);
        step();
        step();
        check("t6_rst_hold_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        step();
        step();
        check("t6_reloaded", 32'(bus.remaining), 2);
        wait_done(200, n);
        check("t6_latency", 32'(n), 8);
        bus.timer_enable = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wash_phase_timer.md
# wash_phase_timer

Per-phase duration timer for the washing-machine controller. It consumes the controller's `timer_enable`, `phase_sel` and mode bits, loads a mode-dependent duration for the active phase (soak/wash/rinse/spin), and counts it down on a prescaled time base. It pauses while the lid is open and returns a one-cycle `timer_done` pulse that drives the controller's phase transitions.

## Interface
- `TICK_DIV`, default 1000: clk cycles per time unit; must be ≥ 2.
- `CNT_W`, default 8: width of the remaining-time counter; must be ≥ 5.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `timer_enable`  in  1  controller is in a timed phase.
- `phase_sel`  in  2  00 soak, 01 wash, 10 rinse, 11 spin.
- `mode`  in  3  {mode1, mode2, mode3} as latched by the controller.
- `lid`  in  1  1 = lid open; pauses counting.
- `cancel`  in  1  abort; highest priority.
- `timer_done`  out  1  one-cycle pulse when the phase duration expires.
- `remaining`  out  CNT_W  time units left in the current phase.
- `busy`  out  1  high in LOAD, RUN, PAUSE and DONE.
- `paused`  out  1  high in PAUSE.

## Operation
- **Mode decode**, priority mode1 > mode2 > mode3:
  - mode1 = heavy, mode2 = normal, mode3 = quick.
  - 000 decodes as quick.
- **Duration table** in time units, order soak/wash/rinse/spin:
  - quick: 2/4/2/2.
  - normal: 4/8/4/4.
  - heavy: 8/16/6/6.
- **States:** IDLE, LOAD, RUN, PAUSE, DONE. All registers are reset to IDLE/zero.
- **IDLE:**
  - `remaining` = 0, prescaler = 0.
  - `timer_enable` = 1 and `cancel` = 0 → LOAD.
- **LOAD:**
  - Latch `phase_sel` into `phase_q`.
  - `remaining` ← dur(mode, phase_sel), prescaler ← 0.
  - Next state is RUN.
- **RUN:**
  - Prescaler counts 0..TICK_DIV-1; tick = (prescaler == TICK_DIV-1), after which it wraps to 0.
  - On tick, `remaining` decrements.
  - Tick with `remaining` == 1 → `remaining` = 0 and state → DONE.
- **PAUSE:**
  - Prescaler and `remaining` are frozen.
  - `lid` = 0 → RUN, resuming from the frozen prescaler value (no restart).
- **DONE:** `timer_done` = 1 for exactly this cycle, then:
  - `timer_enable` = 1 and `phase_sel` ≠ `phase_q` → LOAD.
  - `timer_enable` = 0 → IDLE.
  - Otherwise → IDLE, and re-arm from there. The next LOAD requires `timer_enable` to be seen in IDLE again.
- **Priority in RUN and PAUSE,** highest first:
  1. `cancel` → IDLE, `remaining` cleared.
  2. `timer_enable` = 0 → IDLE, `remaining` cleared.
  3. `phase_sel` ≠ `phase_q` → LOAD (restart on the new phase).
  4. In RUN only: `lid` = 1 → PAUSE. The tick is suppressed in that cycle.
  5. Tick.
- **Cancel in DONE:** the pulse still completes, and the next state is IDLE.
- **Arithmetic:** `remaining` never underflows and never wraps. Table values are zero-extended to CNT_W.

## Timing
- **Reset values:** `timer_done` = 0, `remaining` = 0, `busy` = 0, `paused` = 0. State = IDLE, prescaler = 0.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- **Done latency:** enable sampled at edge k in IDLE → LOAD in cycle k+1 → `timer_done` high in cycle k+2+dur·TICK_DIV, with no pause.
- Each cycle spent in PAUSE adds exactly one cycle to that latency.
- Back-to-back phases:
  - The controller updates `phase_sel` the cycle after `timer_done`.
  - The block then passes through LOAD.
  - The next `timer_done` comes dur·TICK_DIV+2 cycles after the previous one.
- `remaining` updates on the edge after the tick cycle.
- An asynchronous reset mid-phase returns the block to IDLE immediately, with no `timer_done`.

## Structure
- Package `wash_pkg` holds:
  - Phase codes PH_SOAK/PH_WASH/PH_RINSE/PH_SPIN.
  - Mode index enum (QUICK/NORMAL/HEAVY).
  - The state enum.
  - A `phase_duration(mode_idx, phase)` function returning the table value.
- Sub-module `tick_prescaler`, parameterised by TICK_DIV:
  - Inputs: `clk`, `rst_n`, `clr`, `run`.
  - Output: `tick`.
  - The counter width is $clog2(TICK_DIV).

## Test plan
- TICK_DIV=4; mode=001 (quick), phase 00, enable held from cycle 0 → `timer_done` single pulse at cycle 10, `remaining` sequence 2,1,0.
- Same setup, but `lid` = 1 for 5 cycles mid-RUN → pulse at cycle 15, and `remaining` holds its value while `paused` = 1.
- mode=100 (heavy), phases walked 00→01→10→11, with `phase_sel` advanced the cycle after each pulse → pulse spacing 34, 66, 26, 26 cycles.
- `cancel` asserted with `remaining` = 3 → IDLE next cycle, `remaining` = 0, no `timer_done`, `busy` = 0.
- mode=000, phase 01 → quick wash duration, i.e. 4 units = 16 cycles + 2.
- `rst_n` asserted mid-RUN, then released and enable reapplied → outputs zero during reset, and a full duration is reloaded afterward.
